spi_req_arbiter: RTL and testbench
==================================

// Module: spi_req_arbiter
// PURPOSE
// Shares one spi_master request port (req/data_in/address/ack) between NUM_REQ clients.
// Uses round-robin arbitration with an optional lock. A locked client keeps ownership
// across back-to-back requests, so a config write (addr 0), divider write (addr 1) and
// its data transfers run atomically. Sits between client logic and spi_master.
// PARAMETERS
// NUM_REQ     4   number of requesting clients
// DATA_WIDTH  8   width of data_in / spi_data
// ADDR_WIDTH  8   width of address / spi_address
// HOLD_MAX    16  max idle cycles a locked owner may hold the grant without a new req
// ID_WIDTH    $clog2(NUM_REQ)  width of grant_id (derived, not overridable)
// PORTS
// clk          in   1                      system clock, all logic on posedge
// rst          in   1                      synchronous reset, active-high
// req_i        in   NUM_REQ                per-client request, held until its ack_o falls
// lock_i       in   NUM_REQ                per-client lock: keep grant after current transfer
// data_i       in   NUM_REQ*DATA_WIDTH     client data, slice k = client k
// address_i    in   NUM_REQ*ADDR_WIDTH     client address, slice k = client k
// ack_o        out  NUM_REQ                spi_ack routed to the granted client only
// grant_id     out  ID_WIDTH               index of current owner (valid when busy=1)
// busy         out  1                      1 in any state other than IDLE
// spi_req      out  1                      request to spi_master
// spi_data     out  DATA_WIDTH             to spi_master data_in
// spi_address  out  ADDR_WIDTH             to spi_master address
// spi_ack      in   1                      ack from spi_master (high pulse, >=1 cycle)
// BEHAVIOUR
// - Reset: state=IDLE, spi_req=0, spi_data=0, spi_address=0, grant_id=0, busy=0, ptr=0,
//   hold_cnt=0. ack_o is 0 because it is gated by state. Reset mid-transfer aborts
//   immediately, with spi_req low the next cycle.
// - FSM: IDLE, ISSUE, WAIT_DROP, HOLD.
// - IDLE: if any req_i, winner = first set bit scanning ptr, ptr+1, ... (mod NUM_REQ).
//   Register grant_id, spi_data and spi_address from the winner's slice, set spi_req=1,
//   go to ISSUE. spi_req rises 1 cycle after req_i is sampled.
// - ISSUE: spi_req held 1, data/address frozen. ack_o[grant_id] = spi_ack (combinational).
//   On spi_ack falling edge (registered ack_d=1, spi_ack=0), clear spi_req and go to WAIT_DROP.
// - WAIT_DROP: wait for req_i[grant_id]==0.
//   If lock_i[grant_id]=1, go to HOLD with hold_cnt=0.
//   Otherwise go to IDLE with ptr = grant_id+1 (wraps NUM_REQ-1 -> 0).
// - HOLD: grant is retained and other clients are ignored.
//   If req_i[grant_id]=1, recapture data/address, set spi_req=1, go to ISSUE.
//   Else if lock_i[grant_id]=0 or hold_cnt==HOLD_MAX-1, go to IDLE and advance ptr.
//   Else hold_cnt++.
// - A client dropping req_i during ISSUE does not abort: spi_req stays high until the ack
//   completes, because spi_master has no abort.
// - Simultaneous requests: exactly one grant; the rest wait. No client waits more than
//   NUM_REQ-1 unlocked transfers.
// - spi_ack while IDLE/WAIT_DROP/HOLD: ignored, no ack_o asserted.
// - ack_o is one-hot or zero at all times.
// TESTING
// - Reset then single req_i[2], addr 'h08, data 'h15 -> spi_req 1 cycle later,
//   spi_address=8, spi_data='h15; ack_o[2] mirrors spi_ack; ptr=3.
// - req_i=4'b1111 simultaneously, no locks -> grants in order 0,1,2,3; each spi_req
//   separated by one ack cycle; ptr wraps to 0.
// - Client 1 locked: addr 0 data 'h40, addr 1 data 'h01, addr 8 data 'h15, with req_i[0]
//   pending throughout -> client 0 granted only after lock_i[1] drops.
// - Locked owner idle in HOLD for HOLD_MAX=16 cycles -> forced to IDLE on cycle 16,
//   pending client 3 granted next.
// - rst=1 while in ISSUE with spi_ack high -> next cycle spi_req=0, busy=0, ack_o=0,
//   grant_id=0.
// - spi_ack pulse while IDLE -> ack_o stays 0, no state change.

Source files
------------

// File: rtl/spi_req_arbiter_if.sv
// spi_master request bus shared by the arbiter (master side) and spi_master (slave side).
interface spi_req_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  spi_req;
  logic [DATA_WIDTH-1:0] spi_data;
  logic [ADDR_WIDTH-1:0] spi_address;
  logic                  spi_ack;

  modport master (output spi_req, spi_data, spi_address, input spi_ack);
  modport slave  (input spi_req, spi_data, spi_address, output spi_ack);
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master request port between NUM_REQ clients,
// with a per-client lock so multi-transfer sequences run atomically.
module spi_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int HOLD_MAX   = 16,
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0]               lock_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    data_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    address_i,
  output logic [NUM_REQ-1:0]               ack_o,
  output logic [ID_WIDTH-1:0]              grant_id,
  output logic                             busy,
  spi_req_arbiter_if.master                spi
);

  localparam int HC_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DROP, HOLD} state_t;

  state_t                state, state_nx;
  logic [ID_WIDTH-1:0]   ptr, ptr_nx, grant_nx, grant_inc;
  logic [ID_WIDTH-1:0]   winner, cand, sel_id;
  logic                  found;
  logic [HC_W-1:0]       hold_cnt, hold_nx;
  logic                  ack_d;
  logic                  req_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      grant_id        <= '0;
      hold_cnt        <= '0;
      ack_d           <= 1'b0;
      spi.spi_req     <= 1'b0;
      spi.spi_data    <= '0;
      spi.spi_address <= '0;
    end else begin
      state           <= state_nx;
      ptr             <= ptr_nx;
      grant_id        <= grant_nx;
      hold_cnt        <= hold_nx;
      ack_d           <= spi.spi_ack;
      spi.spi_req     <= req_nx;
      spi.spi_data    <= data_nx;
      spi.spi_address <= addr_nx;
    end
  end

  // First requesting client scanning ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_WIDTH'((32'(ptr) + i) % 32'(NUM_REQ));
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant_inc = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign sel_id    = (state == IDLE) ? winner : grant_id;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant_id;
    hold_nx  = hold_cnt;
    req_nx   = spi.spi_req;
    data_nx  = spi.spi_data;
    addr_nx  = spi.spi_address;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = winner;
          data_nx  = data_i[sel_id*DATA_WIDTH +: DATA_WIDTH];
          addr_nx  = address_i[sel_id*ADDR_WIDTH +: ADDR_WIDTH];
          req_nx   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        // spi_master cannot abort, so only the ack falling edge ends the transfer.
        if (ack_d && !spi.spi_ack) begin
          req_nx   = 1'b0;
          state_nx = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!req_i[grant_id]) begin
          if (lock_i[grant_id]) begin
            hold_nx  = '0;
            state_nx = HOLD;
          end else begin
            ptr_nx   = grant_inc;
            state_nx = IDLE;
          end
        end
      end
      HOLD: begin
        if (req_i[grant_id]) begin
          data_nx  = data_i[sel_id*DATA_WIDTH +: DATA_WIDTH];
          addr_nx  = address_i[sel_id*ADDR_WIDTH +: ADDR_WIDTH];
          req_nx   = 1'b1;
          state_nx = ISSUE;
        end else if (!lock_i[grant_id] || hold_cnt == HC_W'(HOLD_MAX - 1)) begin
          ptr_nx   = grant_inc;
          state_nx = IDLE;
        end else begin
          hold_nx  = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack_o = '0;
    if (state == ISSUE) ack_o[grant_id] = spi.spi_ack;
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: single grant, round-robin order, lock/hold,
// hold timeout, reset mid-transfer and stray ack.
module tb_spi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_i, lock_i, ack_o;
  logic [31:0] data_i, address_i;
  logic [1:0]  grant_id;
  logic        busy;
  int          checks = 0;
  int          errors = 0;

  spi_req_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) spi ();

  spi_req_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .HOLD_MAX(16)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .data_i(data_i),
    .address_i(address_i), .ack_o(ack_o), .grant_id(grant_id), .busy(busy), .spi(spi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_client(input int k, input logic [7:0] d, input logic [7:0] a);
    data_i[k*8 +: 8]    = d;
    address_i[k*8 +: 8] = a;
  endtask

  task automatic grant_check(input int id, input logic [7:0] d, input logic [7:0] a);
    tick();
    chk("spi_req_up", 32'(spi.spi_req), 32'd1);
    chk("grant_id", 32'(grant_id), 32'(id));
    chk("spi_data", 32'(spi.spi_data), 32'(d));
    chk("spi_address", 32'(spi.spi_address), 32'(a));
    chk("busy_issue", 32'(busy), 32'd1);
  endtask

  task automatic complete(input int id);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    spi.spi_ack = 1'b1;
    #1 chk("ack_o_mirror", 32'(ack_o), 32'(onehot));
    tick();
    chk("ack_o_held", 32'(ack_o), 32'(onehot));
    spi.spi_ack = 1'b0;
    #1 chk("ack_o_fall", 32'(ack_o), 32'd0);
    tick();
    chk("spi_req_drop", 32'(spi.spi_req), 32'd0);
    chk("busy_wait_drop", 32'(busy), 32'd1);
    req_i[id] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_i = '0; lock_i = '0; data_i = '0; address_i = '0; spi.spi_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_spi_req", 32'(spi.spi_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_ack_o", 32'(ack_o), 32'd0);
    chk("rst_data", 32'(spi.spi_data), 32'd0);
    chk("rst_addr", 32'(spi.spi_address), 32'd0);

    // Single request from client 2.
    set_client(2, 8'h15, 8'h08);
    req_i = 4'b0100;
    #1 chk("req_latency", 32'(spi.spi_req), 32'd0);
    grant_check(2, 8'h15, 8'h08);
    complete(2);
    chk("idle_after_2", 32'(busy), 32'd0);

    // ptr now 3: client 3 beats client 0.
    set_client(0, 8'hA0, 8'h30);
    set_client(3, 8'hA3, 8'h33);
    req_i = 4'b1001;
    grant_check(3, 8'hA3, 8'h33);
    req_i[0] = 1'b0;
    complete(3);
    tick();
    chk("idle_no_req", 32'(busy), 32'd0);

    // All four at once, ptr back at 0.
    for (int k = 0; k < 4; k++) set_client(k, 8'(8'hA0 + k), 8'(8'h30 + k));
    req_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      grant_check(k, 8'(8'hA0 + k), 8'(8'h30 + k));
      complete(k);
    end
    chk("rr_done_idle", 32'(busy), 32'd0);

    // Client 1 locked for three transfers while client 0 waits.
    set_client(1, 8'h40, 8'h00);
    set_client(0, 8'h5A, 8'h77);
    req_i = 4'b0010; lock_i = 4'b0010;
    grant_check(1, 8'h40, 8'h00);
    req_i[0] = 1'b1;
    complete(1);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_grant", 32'(grant_id), 32'd1);
    set_client(1, 8'h01, 8'h01);
    req_i[1] = 1'b1;
    grant_check(1, 8'h01, 8'h01);
    complete(1);
    set_client(1, 8'h15, 8'h08);
    req_i[1] = 1'b1;
    grant_check(1, 8'h15, 8'h08);
    complete(1);
    chk("hold_no_req", 32'(spi.spi_req), 32'd0);
    lock_i = '0;
    tick();
    chk("unlock_idle", 32'(busy), 32'd0);
    grant_check(0, 8'h5A, 8'h77);
    complete(0);

    // HOLD timeout: client 2 locked and idle, client 3 pending.
    set_client(2, 8'h22, 8'h02);
    set_client(3, 8'h33, 8'h03);
    req_i = 4'b0100; lock_i = 4'b0100;
    grant_check(2, 8'h22, 8'h02);
    req_i[3] = 1'b1;
    complete(2);
    for (int c = 1; c < 16; c++) tick();
    chk("hold_cycle15", 32'(busy), 32'd1);
    chk("hold_cycle15_req", 32'(spi.spi_req), 32'd0);
    tick();
    chk("hold_timeout", 32'(busy), 32'd0);
    grant_check(3, 8'h33, 8'h03);
    lock_i = '0;
    complete(3);

    // Reset while in ISSUE with spi_ack high.
    set_client(1, 8'h66, 8'h06);
    req_i = 4'b0010;
    grant_check(1, 8'h66, 8'h06);
    spi.spi_ack = 1'b1;
    rst = 1'b1;
    tick();
    chk("abort_spi_req", 32'(spi.spi_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack_o", 32'(ack_o), 32'd0);
    chk("abort_grant", 32'(grant_id), 32'd0);
    rst = 1'b0; spi.spi_ack = 1'b0; req_i = '0;
    tick();

    // Stray spi_ack while IDLE.
    spi.spi_ack = 1'b1;
    #1 chk("stray_ack_o", 32'(ack_o), 32'd0);
    tick();
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_spi_req", 32'(spi.spi_req), 32'd0);
    spi.spi_ack = 1'b0;
    tick(); tick();
    chk("stray_still_idle", 32'(busy), 32'd0);
    set_client(2, 8'h99, 8'h09);
    req_i = 4'b0100;
    grant_check(2, 8'h99, 8'h09);
    complete(2);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
